fir_band_mac_engine: RTL and testbench
======================================

Name: fir_band_mac_engine

Overview:
- Time-multiplexed single-band FIR tap engine for the 4-band, 10-bit sign-magnitude fixed-point FIR.
- Accepts one input sample per handshake and shifts it into a tap delay line.
- Runs one multiply-accumulate per cycle over all taps, using coefficients of the selected band.
- Sits directly upstream of the 19-bit sign-magnitude product/sum datapath consumers. Instantiates Fx_10bit_Multiplier and owns the saturating accumulation.

Parameters:
- NTAPS, 8, taps per band; power of two, 2..32.
- NBANDS, 4, coefficient banks; power of two.
- TAPW, $clog2(NTAPS), tap index width.
- BANDW, $clog2(NBANDS), band index width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample offered.
- in_ready  out  1  high only in IDLE.
- in_sample  in  10  sign-magnitude sample: [9] sign, [8:0] magnitude.
- in_band  in  BANDW  band applied to this sample.
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_band  in  BANDW  coefficient bank.
- coef_wr_tap  in  TAPW  tap index (0 = newest sample).
- coef_wr_data  in  10  sign-magnitude coefficient.
- coef_wr_drop  out  1  1-cycle pulse: write ignored because not IDLE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  19  sign-magnitude result: [18] sign, [17:0] magnitude.
- out_band  out  BANDW  band of out_data.
- out_sat  out  1  saturation occurred during this result.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: in_ready=0 during the rst cycle, then 1. out_valid=0, out_data=0, out_band=0, out_sat=0, coef_wr_drop=0.
- Reset also clears the delay line and all coefficients to 0 and forces IDLE. Reset mid-MAC discards the partial result; no out_valid follows.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid: delay line shifts (x[0] <= in_sample, x[k] <= x[k-1], x[NTAPS-1] dropped). Band is latched, accumulator is cleared, sat flag is cleared, tap counter k=0, then -> MAC.
  - Coefficient writes apply only in IDLE; a write and a sample accept in the same cycle both take effect. The new coefficient is visible to that sample's MAC.
- MAC:
  - One tap per cycle: acc <= sat_add(acc, x[k]*h[band][k]), k++.
  - After tap NTAPS-1, -> OUT.
  - Stays exactly NTAPS cycles. in_ready=0.
- OUT:
  - out_valid=1; out_data, out_band and out_sat are held stable while out_valid=1 and out_ready=0.
  - On out_ready -> IDLE; out_valid drops the next cycle.
  - out_ready ignored outside OUT.
- Latency: sample accepted at cycle 0 -> out_valid at cycle NTAPS+1. Minimum sample period NTAPS+2 cycles with out_ready held high.
- Product:
  - sign = xs^hs; magnitude = xm*hm (18 bits, max 261121, never overflows).
  - Magnitude 0 forces sign 0 (no -0 enters the accumulator).
- sat_add, sign-magnitude, 18-bit magnitude:
  - Equal signs: magnitude add. If carry out, magnitude = 18'h3FFFF and sat flag set; sign kept.
  - Different signs: larger magnitude minus smaller; sign of larger.
  - Equal magnitudes -> +0.
- out_data is never -0 (19'h40000 is never produced).
- coef_wr_en in MAC or OUT: write discarded, coef_wr_drop pulses the next cycle.

Decomposition:
- Package fir_fx_pkg:
  - SAMPLE_W=10, PROD_W=19, MAG_W=18 constants.
  - Sign-magnitude typedefs for sample and product.
  - FSM state enum.
  - Saturating sign-magnitude add function.
- Sub-module fir_coef_bank: NBANDS x NTAPS x 10 register file, synchronous write, combinational read by (band, tap), synchronous clear on rst.
- Multiplier: one Fx_10bit_Multiplier instance. -0 product normalisation is done in this block.

Test Plan:
- Band 0 all coefficients 10'h001; sample 10'h005 after reset -> out_data=19'h00005, out_band=0, out_valid at cycle 9 (NTAPS=8), out_sat=0.
- Then sample 10'h203 (-3) -> +5-3 = 19'h00002. Then sample 10'h20A (-10) -> 5-3-10 = 19'h40008 (-8).
- Band 2 all coefficients 10'h1FF; 8 samples of 10'h1FF -> 8th result 19'h3FFFF with out_sat=1. The same coefficients with samples alternating 10'h1FF / 10'h3FF never set out_sat.
- Coefficient 10'h001 at tap 0 only; sample 10'h200 (-0) -> out_data=19'h00000. Coefficient 10'h201 with sample 10'h001 -> 19'h40001.
- Hold out_ready=0 for 5 cycles -> out_data stable, in_ready=0, a second in_valid is not accepted. coef_wr_en during MAC -> coef_wr_drop pulse, bank unchanged (readback via a subsequent MAC result).
- Assert rst at MAC cycle 3 -> next cycle IDLE, in_ready=1, out_valid=0. A following sample 10'h005 with band 0 -> 19'h00000, since coefficients are cleared.

Source files
------------

// File: rtl/fir_fx_pkg.sv
// Shared fixed-point types and helpers for the sign-magnitude FIR datapath.
package fir_fx_pkg;

  localparam int SAMPLE_W = 10;
  localparam int PROD_W   = 19;
  localparam int MAG_W    = 18;

  // 10-bit sign-magnitude sample / coefficient.
  typedef struct packed {
    logic                  sign;
    logic [SAMPLE_W-2:0]   mag;
  } sm_sample_t;

  // 19-bit sign-magnitude product / accumulator.
  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } sm_prod_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT
  } fsm_state_t;

  // Sum plus a flag raised when the magnitude had to be clamped.
  typedef struct packed {
    sm_prod_t sum;
    logic     sat;
  } sat_sum_t;

  // Saturating sign-magnitude add. Never returns -0: a cancelling pair
  // yields +0, and equal-sign adds only see -0 if an operand already was -0.
  function automatic sat_sum_t sat_add(input sm_prod_t a, input sm_prod_t b);
    sat_sum_t         r;
    logic [MAG_W:0]   s;
    r = '0;
    s = '0;
    if (a.sign == b.sign) begin
      s = {1'b0, a.mag} + {1'b0, b.mag};
      r.sum.sign = a.sign;
      if (s[MAG_W]) begin
        r.sum.mag = '1;
        r.sat     = 1'b1;
      end else begin
        r.sum.mag = s[MAG_W-1:0];
      end
    end else if (a.mag > b.mag) begin
      r.sum.sign = a.sign;
      r.sum.mag  = a.mag - b.mag;
    end else if (b.mag > a.mag) begin
      r.sum.sign = b.sign;
      r.sum.mag  = b.mag - a.mag;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_band_mac_engine_if.sv
// Sample, coefficient-write and result channels of the FIR band MAC engine.
interface fir_band_mac_engine_if #(
  parameter int NTAPS  = 8,
  parameter int NBANDS = 4
);
  localparam int TAPW  = $clog2(NTAPS);
  localparam int BANDW = $clog2(NBANDS);

  logic             in_valid;
  logic             in_ready;
  logic [9:0]       in_sample;
  logic [BANDW-1:0] in_band;

  logic             coef_wr_en;
  logic [BANDW-1:0] coef_wr_band;
  logic [TAPW-1:0]  coef_wr_tap;
  logic [9:0]       coef_wr_data;
  logic             coef_wr_drop;

  logic             out_valid;
  logic             out_ready;
  logic [18:0]      out_data;
  logic [BANDW-1:0] out_band;
  logic             out_sat;

  // Producer/consumer side that drives samples, coefficients and out_ready.
  modport master (
    output in_valid, in_sample, in_band,
    output coef_wr_en, coef_wr_band, coef_wr_tap, coef_wr_data,
    output out_ready,
    input  in_ready, coef_wr_drop, out_valid, out_data, out_band, out_sat
  );

  // Engine side.
  modport slave (
    input  in_valid, in_sample, in_band,
    input  coef_wr_en, coef_wr_band, coef_wr_tap, coef_wr_data,
    input  out_ready,
    output in_ready, coef_wr_drop, out_valid, out_data, out_band, out_sat
  );
endinterface

// File: rtl/Fx_10bit_Multiplier.sv
// 10-bit x 10-bit sign-magnitude multiplier with a 19-bit sign-magnitude product.
module Fx_10bit_Multiplier
  import fir_fx_pkg::*;
(
  input  logic [SAMPLE_W-1:0] a,
  input  logic [SAMPLE_W-1:0] b,
  output logic [PROD_W-1:0]   p
);

  logic [MAG_W-1:0] a_mag;
  logic [MAG_W-1:0] b_mag;

  assign a_mag = MAG_W'(a[SAMPLE_W-2:0]);
  assign b_mag = MAG_W'(b[SAMPLE_W-2:0]);
  // 511 * 511 = 261121 fits in 18 bits, so the product never overflows.
  assign p     = {a[SAMPLE_W-1] ^ b[SAMPLE_W-1], a_mag * b_mag};

endmodule

// File: rtl/fir_coef_bank.sv
// NBANDS x NTAPS coefficient register file: synchronous write, combinational read.
module fir_coef_bank
  import fir_fx_pkg::*;
#(
  parameter int  NTAPS  = 8,
  parameter int  NBANDS = 4,
  localparam int TAPW   = $clog2(NTAPS),
  localparam int BANDW  = $clog2(NBANDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [BANDW-1:0]    wr_band,
  input  logic [TAPW-1:0]     wr_tap,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic [BANDW-1:0]    rd_band,
  input  logic [TAPW-1:0]     rd_tap,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem [NBANDS][NTAPS];

  // Coefficient storage: cleared by reset, one write per cycle.
  // NOTE: the bank is cleared on reset because an all-zero filter is the
  // defined power-up behaviour; this forces flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NBANDS; b++) begin
        for (int t = 0; t < NTAPS; t++) begin
          mem[b][t] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[wr_band][wr_tap] <= wr_data;
    end
  end

  assign rd_data = mem[rd_band][rd_tap];

endmodule

// File: rtl/fir_band_mac_engine.sv
// Time-multiplexed single-band FIR: one sample in, NTAPS MAC cycles, one result out.
module fir_band_mac_engine
  import fir_fx_pkg::*;
#(
  parameter int  NTAPS  = 8,
  parameter int  NBANDS = 4,
  localparam int TAPW   = $clog2(NTAPS),
  localparam int BANDW  = $clog2(NBANDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  fir_band_mac_engine_if.slave  bus
);

  fsm_state_t          state;
  sm_sample_t          x_q [NTAPS];
  logic [BANDW-1:0]    band_q;
  logic [TAPW-1:0]     k_q;
  sm_prod_t            acc_q;
  logic                sat_q;

  logic                out_valid_q;
  sm_prod_t            out_data_q;
  logic [BANDW-1:0]    out_band_q;
  logic                out_sat_q;
  logic                coef_wr_drop_q;

  logic                accept;
  logic                coef_wr_ok;
  logic [SAMPLE_W-1:0] coef;
  logic [PROD_W-1:0]   prod_raw;
  sm_prod_t            prod;
  sat_sum_t            acc_next;

  // Ready only while idle and out of reset, so nothing is taken in the rst cycle.
  assign bus.in_ready = (state == ST_IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign coef_wr_ok   = bus.coef_wr_en && (state == ST_IDLE);

  fir_coef_bank #(
    .NTAPS  (NTAPS),
    .NBANDS (NBANDS)
  ) u_coef_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (coef_wr_ok),
    .wr_band (bus.coef_wr_band),
    .wr_tap  (bus.coef_wr_tap),
    .wr_data (bus.coef_wr_data),
    .rd_band (band_q),
    .rd_tap  (k_q),
    .rd_data (coef)
  );

  Fx_10bit_Multiplier u_mult (
    .a (x_q[k_q]),
    .b (coef),
    .p (prod_raw)
  );

  // Normalise a zero-magnitude product to +0 before it reaches the accumulator.
  // NOTE: every always_comb output gets a full default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    prod = sm_prod_t'(prod_raw);
    if (prod.mag == '0) begin
      prod.sign = 1'b0;
    end
  end

  assign acc_next = sat_add(acc_q, prod);

  // Tap delay line: newest sample at index 0, shifted on each accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
      end
    end else if (accept) begin
      x_q[0] <= sm_sample_t'(bus.in_sample);
      for (int i = 1; i < NTAPS; i++) begin
        x_q[i] <= x_q[i-1];
      end
    end
  end

  // Control FSM with registered result outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      band_q      <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_band_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            band_q <= bus.in_band;
            k_q    <= '0;
            acc_q  <= '0;
            sat_q  <= 1'b0;
            state  <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_q <= acc_next.sum;
          sat_q <= sat_q | acc_next.sat;
          k_q   <= k_q + TAPW'(1);
          if (k_q == TAPW'(NTAPS - 1)) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc_next.sum;
            out_band_q  <= band_q;
            out_sat_q   <= sat_q | acc_next.sat;
            state       <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // One-cycle pulse flagging a coefficient write that arrived while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      coef_wr_drop_q <= 1'b0;
    end else begin
      coef_wr_drop_q <= bus.coef_wr_en && (state != ST_IDLE);
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_band     = out_band_q;
  assign bus.out_sat      = out_sat_q;
  assign bus.coef_wr_drop = coef_wr_drop_q;

endmodule

// File: tb/tb_fir_band_mac_engine.sv
// Self-checking bench for fir_band_mac_engine against a signed-integer FIR model.
module tb_fir_band_mac_engine;

  localparam int NTAPS  = 8;
  localparam int NBANDS = 4;
  localparam int MAXMAG = 262143;
  localparam int LAT    = NTAPS + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_band_mac_engine_if #(.NTAPS(NTAPS), .NBANDS(NBANDS)) bus ();

  fir_band_mac_engine #(.NTAPS(NTAPS), .NBANDS(NBANDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: coefficient banks and delay line as raw 10-bit codes.
  logic [9:0] coef_m [NBANDS][NTAPS];
  logic [9:0] x_m    [NTAPS];

  function automatic int dec10(input logic [9:0] v);
    int m;
    m = int'(v[8:0]);
    return v[9] ? -m : m;
  endfunction

  function automatic logic [18:0] enc19(input int v);
    logic [17:0] m;
    if (v < 0) begin
      m = 18'(-v);
      return {1'b1, m};
    end
    m = 18'(v);
    return {1'b0, m};
  endfunction

  function automatic void model_clear();
    for (int b = 0; b < NBANDS; b++)
      for (int t = 0; t < NTAPS; t++)
        coef_m[b][t] = '0;
    for (int t = 0; t < NTAPS; t++)
      x_m[t] = '0;
  endfunction

  function automatic void model_shift(input logic [9:0] s);
    for (int i = NTAPS - 1; i > 0; i--)
      x_m[i] = x_m[i-1];
    x_m[0] = s;
  endfunction

  // Running sum in tap order, clamped to +/-MAXMAG after each tap.
  function automatic void model_calc(input int band, output logic [18:0] d, output logic s);
    int acc;
    acc = 0;
    s   = 1'b0;
    for (int k = 0; k < NTAPS; k++) begin
      acc = acc + dec10(x_m[k]) * dec10(coef_m[band][k]);
      if (acc > MAXMAG) begin
        acc = MAXMAG;
        s   = 1'b1;
      end else if (acc < -MAXMAG) begin
        acc = -MAXMAG;
        s   = 1'b1;
      end
    end
    d = enc19(acc);
  endfunction

  task automatic write_coef(input logic [1:0] b, input logic [2:0] t, input logic [9:0] d);
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_band = b;
    bus.coef_wr_tap  = t;
    bus.coef_wr_data = d;
    @(posedge clk);
    coef_m[b][t] = d;
    @(negedge clk);
    bus.coef_wr_en = 1'b0;
  endtask

  // Offers one sample (optionally with a same-cycle coefficient write) and
  // returns the result fields and the accept-to-out_valid latency.
  task automatic run_sample(input logic [9:0] s, input logic [1:0] b,
                            input logic wr, input logic [1:0] wb, input logic [2:0] wt,
                            input logic [9:0] wd,
                            output logic [18:0] d, output logic [1:0] ob,
                            output logic os, output int lat);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      errors++;
      checks++;
      $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    bus.in_valid     = 1'b1;
    bus.in_sample    = s;
    bus.in_band      = b;
    bus.coef_wr_en   = wr;
    bus.coef_wr_band = wb;
    bus.coef_wr_tap  = wt;
    bus.coef_wr_data = wd;
    @(posedge clk);
    if (wr) coef_m[wb][wt] = wd;
    model_shift(s);
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.coef_wr_en = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (bus.out_valid !== 1'b1) begin
      errors++;
      checks++;
      $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles, required 1", bus.out_valid, lat);
    end
    d  = bus.out_data;
    ob = bus.out_band;
    os = bus.out_sat;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 19'h0) begin errors++; $display("FAIL reset_out_data: got %h required 00000", bus.out_data); end
    checks++;
    if (bus.out_band !== 2'd0 || bus.out_sat !== 1'b0 || bus.coef_wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: band=%0d sat=%b drop=%b required 0 0 0", bus.out_band, bus.out_sat, bus.coef_wr_drop);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b required 1", bus.in_ready); end
  endtask

  task automatic test_band0_basic();
    logic [18:0] d;
    logic [1:0]  ob;
    logic        os;
    int          lat;
    logic [9:0]  samples [3] = '{10'h005, 10'h203, 10'h20A};
    logic [18:0] expect_d [3] = '{19'h00005, 19'h00002, 19'h40008};
    for (int t = 0; t < NTAPS; t++) write_coef(2'd0, 3'(t), 10'h001);
    for (int i = 0; i < 3; i++) begin
      run_sample(samples[i], 2'd0, 1'b0, 2'd0, 3'd0, 10'h0, d, ob, os, lat);
      checks++;
      if (d !== expect_d[i]) begin errors++; $display("FAIL basic_data[%0d]: got %h required %h", i, d, expect_d[i]); end
      checks++;
      if (ob !== 2'd0 || os !== 1'b0) begin errors++; $display("FAIL basic_band_sat[%0d]: band=%0d sat=%b required 0 0", i, ob, os); end
      checks++;
      if (lat !== LAT) begin errors++; $display("FAIL basic_latency[%0d]: got %0d required %0d", i, lat, LAT); end
    end
  endtask

  task automatic test_saturation();
    logic [18:0] d, ed;
    logic [1:0]  ob;
    logic        os, es;
    int          lat;
    for (int t = 0; t < NTAPS; t++) write_coef(2'd2, 3'(t), 10'h1FF);
    for (int i = 0; i < NTAPS; i++) begin
      run_sample(10'h1FF, 2'd2, 1'b0, 2'd0, 3'd0, 10'h0, d, ob, os, lat);
      model_calc(2, ed, es);
      checks++;
      if (d !== ed || os !== es || ob !== 2'd2) begin
        errors++;
        $display("FAIL sat_ramp[%0d]: data=%h sat=%b band=%0d required %h %b 2", i, d, os, ob, ed, es);
      end
    end
    checks++;
    if (d !== 19'h3FFFF || os !== 1'b1) begin errors++; $display("FAIL sat_final: data=%h sat=%b required 3ffff 1", d, os); end
    // Flush the line with zeros, then alternate +511/-511: the sums cancel pairwise.
    for (int i = 0; i < NTAPS; i++) begin
      run_sample(10'h000, 2'd2, 1'b0, 2'd0, 3'd0, 10'h0, d, ob, os, lat);
      model_calc(2, ed, es);
      checks++;
      if (d !== ed || os !== es) begin errors++; $display("FAIL sat_flush[%0d]: data=%h sat=%b required %h %b", i, d, os, ed, es); end
    end
    for (int i = 0; i < NTAPS; i++) begin
      run_sample((i % 2 == 0) ? 10'h1FF : 10'h3FF, 2'd2, 1'b0, 2'd0, 3'd0, 10'h0, d, ob, os, lat);
      model_calc(2, ed, es);
      checks++;
      if (d !== ed || os !== 1'b0) begin errors++; $display("FAIL sat_alternate[%0d]: data=%h sat=%b required %h 0", i, d, os, ed); end
    end
  endtask

  task automatic test_neg_zero();
    logic [18:0] d;
    logic [1:0]  ob;
    logic        os;
    int          lat;
    write_coef(2'd1, 3'd0, 10'h001);
    run_sample(10'h200, 2'd1, 1'b0, 2'd0, 3'd0, 10'h0, d, ob, os, lat);
    checks++;
    if (d !== 19'h00000 || ob !== 2'd1) begin errors++; $display("FAIL neg_zero: data=%h band=%0d required 00000 1", d, ob); end
    // Coefficient written in the same cycle as the sample must apply to it.
    run_sample(10'h001, 2'd1, 1'b1, 2'd1, 3'd0, 10'h201, d, ob, os, lat);
    checks++;
    if (d !== 19'h40001) begin errors++; $display("FAIL same_cycle_coef: data=%h required 40001", d); end
  endtask

  task automatic test_backpressure_and_drop();
    logic [18:0] d, ed, held;
    logic [1:0]  ob;
    logic        os, es;
    int          n, lat;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sample = 10'h011;
    bus.in_band   = 2'd0;
    @(posedge clk);
    model_shift(10'h011);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_band = 2'd0;
    bus.coef_wr_tap  = 3'd0;
    bus.coef_wr_data = 10'h0FF;
    @(negedge clk);
    bus.coef_wr_en = 1'b0;
    checks++;
    if (bus.coef_wr_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b required 1", bus.coef_wr_drop); end
    @(negedge clk);
    checks++;
    if (bus.coef_wr_drop !== 1'b0) begin errors++; $display("FAIL drop_width: got %b required 0", bus.coef_wr_drop); end
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    model_calc(0, ed, es);
    held = bus.out_data;
    checks++;
    if (bus.out_valid !== 1'b1 || held !== ed) begin
      errors++;
      $display("FAIL hold_first: valid=%b data=%h required 1 %h", bus.out_valid, held, ed);
    end
    bus.in_valid  = 1'b1;
    bus.in_sample = 10'h07F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: valid=%b data=%h ready=%b required 1 %h 0", i, bus.out_valid, bus.out_data, bus.in_ready, held);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b required 0", bus.out_valid); end
    // A rejected sample or an applied dropped write would both change this sum.
    run_sample(10'h001, 2'd0, 1'b0, 2'd0, 3'd0, 10'h0, d, ob, os, lat);
    model_calc(0, ed, es);
    checks++;
    if (d !== ed) begin errors++; $display("FAIL after_hold_readback: data=%h required %h", d, ed); end
  endtask

  task automatic test_random();
    logic [18:0] d, ed;
    logic [1:0]  ob, b, wb;
    logic        os, es, wr;
    logic [2:0]  wt;
    logic [9:0]  s, wd;
    int          lat;
    for (int i = 0; i < 24; i++) begin
      for (int w = 0; w < int'($urandom_range(0, 2)); w++)
        write_coef(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 10'($urandom));
      b  = 2'($urandom_range(0, 3));
      s  = 10'($urandom);
      if (i % 5 == 0) s[8:0] = 9'h1FF;
      wr = ($urandom_range(0, 3) == 0);
      wb = 2'($urandom_range(0, 3));
      wt = 3'($urandom_range(0, 7));
      wd = 10'($urandom);
      run_sample(s, b, wr, wb, wt, wd, d, ob, os, lat);
      model_calc(int'(b), ed, es);
      checks++;
      if (d !== ed || os !== es) begin errors++; $display("FAIL rand_data[%0d]: data=%h sat=%b required %h %b", i, d, os, ed, es); end
      checks++;
      if (ob !== b || lat !== LAT) begin errors++; $display("FAIL rand_band_lat[%0d]: band=%0d lat=%0d required %0d %0d", i, ob, lat, b, LAT); end
    end
  endtask

  task automatic test_reset_mid_mac();
    logic [18:0] d;
    logic [1:0]  ob;
    logic        os;
    int          lat, seen;
    bus.in_valid  = 1'b1;
    bus.in_sample = 10'h011;
    bus.in_band   = 2'd0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_mac_reset: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mid_mac_no_output: out_valid seen %0d cycles, required 0", seen); end
    run_sample(10'h005, 2'd0, 1'b0, 2'd0, 3'd0, 10'h0, d, ob, os, lat);
    checks++;
    if (d !== 19'h00000 || lat !== LAT) begin
      errors++;
      $display("FAIL after_reset_cleared: data=%h lat=%0d required 00000 %0d", d, lat, LAT);
    end
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_sample    = '0;
    bus.in_band      = '0;
    bus.coef_wr_en   = 1'b0;
    bus.coef_wr_band = '0;
    bus.coef_wr_tap  = '0;
    bus.coef_wr_data = '0;
    bus.out_ready    = 1'b1;
    rst              = 1'b1;
    test_reset();
    test_band0_basic();
    test_saturation();
    test_neg_zero();
    test_backpressure_and_drop();
    test_random();
    test_reset_mid_mac();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
